// File: rtl/send_arb_pkg.sv
// Shared types and limits for the send_arbiter four-phase handshake arbiter.
package send_arb_pkg;

  localparam int N_REQ_MAX = 8;
  localparam int IDX_W     = $clog2(N_REQ_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACKH = 2'd2,
    RTZ  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/send_arbiter_sync2.sv
// sync2: two-flop synchronizer, async active-low reset to zero.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_r;
  logic [W-1:0] sync_r;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= {W{1'b0}};
      sync_r <= {W{1'b0}};
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/send_arbiter.sv
// send_arbiter: round-robin arbiter of N_REQ four-phase senders onto one shared stage.
// Optional input synchronizers are enabled with `define SEND_ARBITER_SYNC_EN.
module send_arbiter
  import send_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic             CLK,
  input  logic             MR_N,
  input  logic [N_REQ-1:0] Send_in,
  output logic [N_REQ-1:0] Ack_out,
  output logic             Send_out,
  input  logic             Ack_in,
  output logic [N_REQ-1:0] Grant,
  output logic             CP,
  output logic             Busy,
  output logic             Err
);

  logic [N_REQ-1:0]     send_s;
  logic                 ack_s;
  logic [N_REQ_MAX-1:0] send_pad_s;
  logic [IDX_W-1:0]     pick_s;

  arb_state_e           state_r, state_s;
  logic [N_REQ-1:0]     grant_r, grant_s;
  logic [N_REQ-1:0]     ack_out_r, ack_out_s;
  logic [IDX_W-1:0]     gidx_r, gidx_s;
  logic [IDX_W-1:0]     last_r, last_s;
  logic                 send_out_r, send_out_s;
  logic                 cp_r, cp_s;
  logic                 busy_r, busy_s;
  logic                 err_r, err_s;

`ifdef SEND_ARBITER_SYNC_EN
  sync2 #(.W(N_REQ)) u_sync_send (.clk(CLK), .rst_n(MR_N), .d(Send_in), .q(send_s));
  sync2 #(.W(1))     u_sync_ack  (.clk(CLK), .rst_n(MR_N), .d(Ack_in),  .q(ack_s));
`else
  assign send_s = Send_in;
  assign ack_s  = Ack_in;
`endif

  // First requester found searching upward from last+1, wrapping at N_REQ
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] last);
    logic [N_REQ_MAX-1:0] req_pad;
    logic [IDX_W-1:0]     pick;
    int                   idx;
    req_pad = N_REQ_MAX'(req);
    pick    = last;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % N_REQ;
      if (req_pad[IDX_W'(idx)]) pick = IDX_W'(idx);
    end
    return pick;
  endfunction

  function automatic logic [N_REQ-1:0] to_onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh = {N_REQ{1'b0}};
    for (int i = 0; i < N_REQ; i++) oh[i] = (IDX_W'(i) == idx);
    return oh;
  endfunction

  assign send_pad_s = N_REQ_MAX'(send_s);

  // Next-state and next-output decode
  always_comb begin
    state_s    = state_r;
    grant_s    = grant_r;
    gidx_s     = gidx_r;
    last_s     = last_r;
    send_out_s = send_out_r;
    ack_out_s  = ack_out_r;
    cp_s       = 1'b0;
    err_s      = err_r;
    pick_s     = rr_pick(send_s, last_r);
    case (state_r)
      IDLE: begin
        // A stray stage acknowledge is flagged and holds off granting until it clears
        if (ack_s) begin
          err_s = 1'b1;
        end else if (|send_s) begin
          gidx_s     = pick_s;
          grant_s    = to_onehot(pick_s);
          send_out_s = 1'b1;
          state_s    = REQ;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (!send_pad_s[gidx_r]) begin
          err_s = 1'b1;
        end else if (ack_s) begin
          ack_out_s = grant_r;
          cp_s      = 1'b1;
          state_s   = ACKH;
        end else begin
          state_s = REQ;
        end
      end
      ACKH: begin
        if (!send_pad_s[gidx_r]) begin
          ack_out_s  = {N_REQ{1'b0}};
          send_out_s = 1'b0;
          state_s    = RTZ;
        end else begin
          state_s = ACKH;
        end
      end
      RTZ: begin
        if (!ack_s) begin
          grant_s = {N_REQ{1'b0}};
          last_s  = gidx_r;
          state_s = IDLE;
        end else begin
          state_s = RTZ;
        end
      end
      default: begin
        state_s    = IDLE;
        grant_s    = {N_REQ{1'b0}};
        ack_out_s  = {N_REQ{1'b0}};
        send_out_s = 1'b0;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State, round-robin pointer and registered outputs
  always_ff @(posedge CLK or negedge MR_N) begin
    if (!MR_N) begin
      state_r    <= IDLE;
      grant_r    <= {N_REQ{1'b0}};
      ack_out_r  <= {N_REQ{1'b0}};
      gidx_r     <= {IDX_W{1'b0}};
      last_r     <= IDX_W'(N_REQ - 1);
      send_out_r <= 1'b0;
      cp_r       <= 1'b0;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      grant_r    <= grant_s;
      ack_out_r  <= ack_out_s;
      gidx_r     <= gidx_s;
      last_r     <= last_s;
      send_out_r <= send_out_s;
      cp_r       <= cp_s;
      busy_r     <= busy_s;
      err_r      <= err_s;
    end
  end

  assign Grant    = grant_r;
  assign Ack_out  = ack_out_r;
  assign Send_out = send_out_r;
  assign CP       = cp_r;
  assign Busy     = busy_r;
  assign Err      = err_r;

endmodule

// File: tb/tb_send_arbiter.sv
// Bench for send_arbiter (N_REQ=4, no synchronizers): handshake-level model,
// per-cycle compare, directed scenarios and randomized legal four-phase traffic.
module tb_send_arbiter;

  localparam int N = 4;

  logic         CLK    = 1'b0;
  logic         MR_N   = 1'b1;
  logic         Ack_in = 1'b0;
  logic [N-1:0] Send_in = {N{1'b0}};
  logic [N-1:0] Ack_out, Grant;
  logic         Send_out, CP, Busy, Err;

  int checks = 0;
  int errors = 0;

  // Model: owner index (-1 = nobody), and which handshake wires are up
  int m_owner = -1;
  int m_last  = N - 1;
  bit m_sendo = 1'b0;
  bit m_acked = 1'b0;
  bit m_cp    = 1'b0;
  bit m_err   = 1'b0;

  send_arbiter #(.N_REQ(N)) dut (
    .CLK(CLK), .MR_N(MR_N), .Send_in(Send_in), .Ack_out(Ack_out),
    .Send_out(Send_out), .Ack_in(Ack_in), .Grant(Grant), .CP(CP),
    .Busy(Busy), .Err(Err)
  );

  always #5 CLK = ~CLK;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkv(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_last = N - 1;
    m_sendo = 1'b0; m_acked = 1'b0; m_cp = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] s, input logic a);
    bit found;
    int idx;
    m_cp = 1'b0;
    if (m_owner < 0) begin
      if (a) m_err = 1'b1;
      else if (s != 0) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          idx = (m_last + k) % N;
          if (!found && s[idx]) begin m_owner = idx; found = 1'b1; end
        end
        m_sendo = 1'b1;
      end
    end else if (m_sendo && !m_acked) begin
      if (!s[m_owner]) m_err = 1'b1;
      else if (a) begin m_acked = 1'b1; m_cp = 1'b1; end
    end else if (m_acked) begin
      if (!s[m_owner]) begin m_acked = 1'b0; m_sendo = 1'b0; end
    end else begin
      if (!a) begin m_last = m_owner; m_owner = -1; end
    end
  endtask

  // Per-cycle compare against the model, sampled 1 time unit after the edge
  initial begin
    logic [N-1:0] eg;
    forever begin
      @(posedge CLK);
      if (!MR_N) model_reset();
      else model_step(Send_in, Ack_in);
      #1;
      eg = (m_owner < 0) ? {N{1'b0}} : (N'(1) << m_owner);
      chkv("cmp_grant",   Grant,   eg);
      chkv("cmp_ack_out", Ack_out, m_acked ? eg : {N{1'b0}});
      chk1("cmp_send_out", Send_out, m_sendo);
      chk1("cmp_cp",       CP,       m_cp);
      chk1("cmp_busy",     Busy,     m_owner >= 0);
      chk1("cmp_err",      Err,      m_err);
    end
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    MR_N = 1'b0; Send_in = {N{1'b0}}; Ack_in = 1'b0;
    tick(); tick();
    MR_N = 1'b1;
  endtask

  task automatic do_txn(input logic [N-1:0] mask, input int exp_w, input string tag);
    int n;
    n = 0;
    Send_in = mask;
    tick();
    while (Send_out !== 1'b1 && n < 20) begin tick(); n++; end
    chkv({tag, "_grant"}, Grant, N'(1) << exp_w);
    Ack_in = 1'b1; tick();
    Send_in = mask & ~(N'(1) << exp_w); tick();
    Ack_in = 1'b0; tick();
  endtask

  initial begin
    // Asynchronous reset, checked between clock edges
    #1 MR_N = 1'b0;
    #1;
    chkv("rst_grant", Grant, 4'b0000);
    chkv("rst_ack_out", Ack_out, 4'b0000);
    chk1("rst_send_out", Send_out, 1'b0);
    chk1("rst_cp", CP, 1'b0);
    chk1("rst_busy", Busy, 1'b0);
    chk1("rst_err", Err, 1'b0);
    tick(); tick();
    MR_N = 1'b1;

    // Single requester, first edge after release grants
    Send_in = 4'b0001;
    tick();
    chk1("s1_send_out", Send_out, 1'b1);
    chkv("s1_grant", Grant, 4'b0001);
    chk1("s1_busy", Busy, 1'b1);
    tick();
    Ack_in = 1'b1;
    tick();
    chk1("s1_cp", CP, 1'b1);
    chkv("s1_ack_out", Ack_out, 4'b0001);
    tick();
    chk1("s1_cp_pulse", CP, 1'b0);
    Send_in = 4'b0000;
    tick();
    chkv("s1_ack_clr", Ack_out, 4'b0000);
    chk1("s1_send_clr", Send_out, 1'b0);
    chkv("s1_grant_held", Grant, 4'b0001);
    Ack_in = 1'b0;
    tick();
    chkv("s1_grant_clr", Grant, 4'b0000);
    chk1("s1_idle", Busy, 1'b0);

    // Contention, then fairness between 0 and 2
    do_reset();
    for (int w = 0; w < N; w++) do_txn(4'b1111, w, "cont");
    for (int r = 0; r < 4; r++) do_txn(4'b0101, (r % 2) * 2, "fair");

    // Randomized legal four-phase traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!Send_in[i] && !Ack_out[i] && $urandom_range(3, 0) == 0) Send_in[i] = 1'b1;
        else if (Send_in[i] && Ack_out[i] && $urandom_range(1, 0) == 0) Send_in[i] = 1'b0;
      end
      if (Send_out && !Ack_in && $urandom_range(2, 0) == 0) Ack_in = 1'b1;
      else if (!Send_out && Ack_in && $urandom_range(1, 0) == 0) Ack_in = 1'b0;
      tick();
    end
    chk1("rand_no_err", Err, 1'b0);

    // Stage acknowledge while idle
    do_reset();
    Ack_in = 1'b1; Send_in = 4'b0010;
    tick();
    chk1("idle_ack_err", Err, 1'b1);
    chk1("idle_ack_busy", Busy, 1'b0);
    chkv("idle_ack_grant", Grant, 4'b0000);
    Ack_in = 1'b0;
    tick();
    chkv("idle_ack_late_grant", Grant, 4'b0010);
    chk1("idle_ack_send", Send_out, 1'b1);
    Ack_in = 1'b1; tick();
    Send_in = 4'b0000; tick();
    Ack_in = 1'b0; tick();

    // Granted requester withdraws before the acknowledge
    do_reset();
    Send_in = 4'b0001;
    tick();
    Send_in = 4'b0000;
    tick();
    chk1("drop_err", Err, 1'b1);
    chk1("drop_send_held", Send_out, 1'b1);
    chkv("drop_grant_held", Grant, 4'b0001);
    chkv("drop_no_ack", Ack_out, 4'b0000);
    Send_in = 4'b0001; Ack_in = 1'b1;
    tick();
    chkv("drop_recover_ack", Ack_out, 4'b0001);
    Send_in = 4'b0000; tick();
    Ack_in = 1'b0; tick();
    chk1("drop_recover_idle", Busy, 1'b0);

    // Reset in the middle of ACKH
    Send_in = 4'b0001;
    tick();
    Ack_in = 1'b1;
    tick();
    chkv("mid_ackh", Ack_out, 4'b0001);
    #2 MR_N = 1'b0;
    #1;
    chkv("mid_rst_grant", Grant, 4'b0000);
    chkv("mid_rst_ack", Ack_out, 4'b0000);
    chk1("mid_rst_send", Send_out, 1'b0);
    chk1("mid_rst_busy", Busy, 1'b0);
    chk1("mid_rst_err", Err, 1'b0);
    chk1("mid_rst_cp", CP, 1'b0);
    Send_in = 4'b0000; Ack_in = 1'b0;
    tick();
    MR_N = 1'b1; Send_in = 4'b0100;
    tick();
    chkv("post_rst_grant", Grant, 4'b0100);
    chk1("post_rst_send", Send_out, 1'b1);
    Ack_in = 1'b1; tick();
    Send_in = 4'b0000; tick();
    Ack_in = 1'b0; tick();
    chk1("post_rst_idle", Busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/send_arbiter.md
SEND_ARBITER -- requirements
Module: send_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requester handshake channels (2..8).
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 MR_N  input  1  master reset; asynchronous assertion, active-low.
REQ-004 Send_in  input  N_REQ  per-requester four-phase request (bit i = requester i).
REQ-005 Ack_out  output  N_REQ  per-requester four-phase acknowledge.
REQ-006 Send_out  output  1  request to the shared pipeline stage.
REQ-007 Ack_in  input  1  acknowledge from the shared pipeline stage.
REQ-008 Grant  output  N_REQ  one-hot current owner; all-zero when idle.
REQ-009 CP  output  1  one-cycle pulse when the shared stage accepts a token.
REQ-010 Busy  output  1  high in every state except IDLE.
REQ-011 Err  output  1  sticky protocol-violation flag.

Function
REQ-012 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-013 FSM states: IDLE, REQ, ACKH, RTZ.
REQ-014 IDLE: if any Send_in bit is high, select the winner round-robin, set Grant, set Send_out=1 and go to REQ on the next edge; otherwise stay.
REQ-015 Round-robin: search starts at (last_winner+1) mod N_REQ; last_winner resets to N_REQ-1, so requester 0 wins first.
REQ-016 REQ: hold Send_out=1 until Ack_in=1; then set Ack_out[g]=1, pulse CP for one cycle and go to ACKH.
REQ-017 ACKH: hold Ack_out[g]=1 until Send_in[g]=0; then clear Ack_out[g], clear Send_out and go to RTZ.
REQ-018 RTZ: wait for Ack_in=0; then clear Grant, update last_winner=g and go to IDLE.
REQ-019 Latency: Send_in[i] high in IDLE gives Send_out high 1 cycle later (excluding synchronizers); minimum full transaction is 4 cycles.
REQ-020 Non-granted requesters: Send_in is ignored and Ack_out is held at 0 until the arbiter returns to IDLE.
REQ-021 Simultaneous requests in IDLE: exactly one winner, per REQ-015.
REQ-022 Send_in[g] falling while in REQ: Send_out stays high, Err is set, and the state is unchanged.
REQ-023 Ack_in high while in IDLE: no state change and Err is set; this condition SHALL NOT block a later grant once Ack_in is low.
REQ-024 Back-to-back operation: IDLE→REQ is allowed in the cycle after RTZ→IDLE; no extra idle cycle is required.

Reset
REQ-025 MR_N low SHALL force the following immediately, regardless of CLK and mid-transaction: state=IDLE, Send_out=0, Ack_out=0, Grant=0, CP=0, Busy=0, Err=0, last_winner=N_REQ-1.
REQ-026 Reset release SHALL take effect only on a CLK edge; the first possible grant is on the first edge with MR_N high.
REQ-027 Err is cleared only by reset.

Configuration
REQ-028 Macro SEND_ARBITER_SYNC_EN defined: every Send_in bit and Ack_in pass through 2-flop synchronizers before the FSM; latency in REQ-019 increases by 2 cycles.
REQ-029 Macro undefined: inputs are sampled directly; the inputs are required to be synchronous to CLK.

Structure
REQ-030 Shared package send_arb_pkg SHALL hold the state enum (IDLE, REQ, ACKH, RTZ) and N_REQ_MAX=8.
REQ-031 One sub-module, sync2 (2-flop synchronizer with async active-low reset to 0), is instantiated only under SEND_ARBITER_SYNC_EN.
REQ-032 Round-robin selection SHALL be a function inside send_arbiter, not a separate module.

Verification (N_REQ=4, macro undefined)
REQ-033 Single requester: Send_in=0001, stage acks after 2 cycles → Grant=0001, Send_out high at cycle 1, CP one pulse, Ack_out=0001, return to IDLE after Ack_in falls.
REQ-034 Contention: Send_in=1111 held for four transactions → winner order 0,1,2,3; Grant never has more than one bit set.
REQ-035 Fairness: requester 0 re-requests immediately while requester 2 waits → grants alternate 0,2,0,2.
REQ-036 Violation: Send_in[g] dropped during REQ → Err=1, Send_out held high; Ack_in stimulus in IDLE → Err=1, state stays IDLE.
REQ-037 Reset mid-transaction: MR_N low during ACKH → all outputs 0 immediately; after release, Send_in=0100 is granted to requester 2.
REQ-038 With SEND_ARBITER_SYNC_EN: repeat REQ-033 → Send_out rises 3 cycles after Send_in.
